// File: rtl/pipeline_ctrl.sv
// Pipeline control: priority stall vector, branch redirect/flush handshake toward IF,
// saturating stall-cycle counter and a sticky memory-wait watchdog.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             ex_b_flag,
  input  logic [31:0]      ex_b_target,
  input  logic             redirect_ack,
  output logic [5:0]       stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err_timeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    S_RUN,
    S_REDIRECT
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [5:0]        stall_req;
  logic              branch_accept;

  // The most downstream request wins; each one freezes its own stage and everything upstream.
  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_mem)     stall_req = 6'b011111;
    else if (stallreq_ex) stall_req = 6'b001111;
    else if (stallreq_id) stall_req = 6'b000111;
    else if (stallreq_if) stall_req = 6'b000011;
  end

  assign stall         = rst_n ? stall_req : 6'b000000;
  assign branch_accept = ex_b_flag & ~stall_req[3];

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      S_RUN: begin
        if (branch_accept) begin
          state_d       = S_REDIRECT;
          redirect_pc_d = ex_b_target;
        end
      end
      S_REDIRECT: begin
        // A newer branch supersedes the pending target even when the old one is acked now.
        if (branch_accept) begin
          redirect_pc_d = ex_b_target;
        end else if (redirect_ack) begin
          state_d       = S_RUN;
          redirect_pc_d = 32'h0;
        end
      end
      default: begin
        state_d       = S_RUN;
        redirect_pc_d = 32'h0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall != 6'b000000) && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);

    wait_d = wait_q;
    if (!stallreq_mem)
      wait_d = '0;
    else if (wait_q != WAIT_W'(MEM_TIMEOUT))
      wait_d = wait_q + WAIT_W'(1);

    err_d = err_q | (wait_d == WAIT_W'(MEM_TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RUN;
      redirect_pc_q <= 32'h0;
      stall_cnt_q   <= '0;
      wait_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      stall_cnt_q   <= stall_cnt_d;
      wait_q        <= wait_d;
      err_q         <= err_d;
    end
  end

  assign redirect_valid = (state_q == S_REDIRECT);
  assign flush_if_id    = (state_q == S_REDIRECT);
  assign flush_id_ex    = (state_q == S_REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign stall_cnt      = stall_cnt_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes expected outputs, a negedge monitor checks them.
module tb_pipeline_ctrl;

  localparam logic [5:0] M_ST  = 6'b000001;
  localparam logic [5:0] M_RV  = 6'b000010;
  localparam logic [5:0] M_PC  = 6'b000100;
  localparam logic [5:0] M_FL  = 6'b001000;
  localparam logic [5:0] M_ERR = 6'b010000;
  localparam logic [5:0] M_CNT = 6'b100000;
  localparam logic [5:0] M_ALL = 6'b111111;

  typedef struct {
    string       name;
    logic [5:0]  mask;
    logic [5:0]  stall;
    logic        rv;
    logic [31:0] pc;
    logic        fl;
    logic        err;
    logic [3:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        ex_b_flag;
  logic [31:0] ex_b_target;
  logic        redirect_ack;
  logic [5:0]  stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if_id, flush_id_ex;
  logic [3:0]  stall_cnt;
  logic        err_timeout;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stallreq_if    (stallreq_if),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .stallreq_mem   (stallreq_mem),
    .ex_b_flag      (ex_b_flag),
    .ex_b_target    (ex_b_target),
    .redirect_ack   (redirect_ack),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .stall_cnt      (stall_cnt),
    .err_timeout    (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge; req = {mem, ex, id, if}.
  task automatic applyStimulus(input logic rst, input logic [3:0] req, input logic flag,
                               input logic [31:0] tgt, input logic ack);
    @(posedge clk);
    #1;
    rst_n        = rst;
    stallreq_if  = req[0];
    stallreq_id  = req[1];
    stallreq_ex  = req[2];
    stallreq_mem = req[3];
    ex_b_flag    = flag;
    ex_b_target  = tgt;
    redirect_ack = ack;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] mask, input logic [5:0] st,
                             input logic rv, input logic [31:0] pc, input logic fl,
                             input logic err, input logic [3:0] cnt);
    exp_t e;
    e.name = name; e.mask = mask; e.stall = st; e.rv = rv;
    e.pc = pc; e.fl = fl; e.err = err; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.mask[0]) cmp(e.name, "stall", {26'h0, stall}, {26'h0, e.stall});
      if (e.mask[1]) cmp(e.name, "redirect_valid", {31'h0, redirect_valid}, {31'h0, e.rv});
      if (e.mask[2]) cmp(e.name, "redirect_pc", redirect_pc, e.pc);
      if (e.mask[3]) begin
        cmp(e.name, "flush_if_id", {31'h0, flush_if_id}, {31'h0, e.fl});
        cmp(e.name, "flush_id_ex", {31'h0, flush_id_ex}, {31'h0, e.fl});
      end
      if (e.mask[4]) cmp(e.name, "err_timeout", {31'h0, err_timeout}, {31'h0, e.err});
      if (e.mask[5]) cmp(e.name, "stall_cnt", {28'h0, stall_cnt}, {28'h0, e.cnt});
    end
  end

  initial begin
    rst_n = 1'b1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    ex_b_flag = 0; ex_b_target = 32'h0; redirect_ack = 0;

    // Reset with every request high, then release with memory busy
    applyStimulus(0, 4'b1111, 1, 32'hDEAD_BEEF, 1);
    checkOutput("reset", M_ALL, 6'h00, 0, 32'h0, 0, 0, 4'h0);
    applyStimulus(1, 4'b1000, 0, 32'h0, 0);
    checkOutput("release_mem", M_ST | M_CNT | M_ERR, 6'h1F, 0, 32'h0, 0, 0, 4'h0);

    // Priority
    applyStimulus(1, 4'b0011, 0, 32'h0, 0);
    checkOutput("prio_if_id", M_ST | M_CNT, 6'h07, 0, 32'h0, 0, 0, 4'h1);
    applyStimulus(1, 4'b0111, 0, 32'h0, 0);
    checkOutput("prio_if_id_ex", M_ST | M_CNT, 6'h0F, 0, 32'h0, 0, 0, 4'h2);
    applyStimulus(1, 4'b1111, 0, 32'h0, 0);
    checkOutput("prio_all", M_ST | M_CNT, 6'h1F, 0, 32'h0, 0, 0, 4'h3);
    applyStimulus(1, 4'b0000, 0, 32'h0, 0);
    checkOutput("prio_none", M_ST | M_CNT, 6'h00, 0, 32'h0, 0, 0, 4'h4);

    // Branch acked on its third valid cycle
    applyStimulus(1, 4'b0000, 1, 32'h0000_0100, 0);
    checkOutput("br_issue", M_ST | M_RV | M_FL, 6'h00, 0, 32'h0, 0, 0, 4'h0);
    applyStimulus(1, 4'b0000, 0, 32'h0, 0);
    checkOutput("br_c1", M_RV | M_PC | M_FL, 6'h00, 1, 32'h100, 1, 0, 4'h0);
    applyStimulus(1, 4'b0000, 0, 32'h0, 0);
    checkOutput("br_c2", M_RV | M_PC | M_FL, 6'h00, 1, 32'h100, 1, 0, 4'h0);
    applyStimulus(1, 4'b0000, 0, 32'h0, 1);
    checkOutput("br_c3_ack", M_RV | M_PC | M_FL, 6'h00, 1, 32'h100, 1, 0, 4'h0);
    applyStimulus(1, 4'b0000, 0, 32'h0, 0);
    checkOutput("br_drop", M_RV | M_FL, 6'h00, 0, 32'h0, 0, 0, 4'h0);

    // Branch under EX stall is ignored until the stall clears
    applyStimulus(1, 4'b0100, 1, 32'h0000_01C0, 0);
    checkOutput("exs_1", M_ST | M_RV | M_CNT, 6'h0F, 0, 32'h0, 0, 0, 4'h4);
    applyStimulus(1, 4'b0100, 1, 32'h0000_01C0, 0);
    checkOutput("exs_2", M_RV | M_FL | M_CNT, 6'h0F, 0, 32'h0, 0, 0, 4'h5);
    applyStimulus(1, 4'b0000, 1, 32'h0000_01C0, 0);
    checkOutput("exs_release", M_ST | M_RV | M_CNT, 6'h00, 0, 32'h0, 0, 0, 4'h6);
    applyStimulus(1, 4'b0000, 0, 32'h0, 0);
    checkOutput("exs_redirect", M_RV | M_PC | M_FL, 6'h00, 1, 32'h1C0, 1, 0, 4'h0);
    applyStimulus(1, 4'b0000, 1, 32'h0000_0200, 1);
    checkOutput("ack_newflag", M_RV | M_PC, 6'h00, 1, 32'h1C0, 1, 0, 4'h0);
    applyStimulus(1, 4'b0000, 0, 32'h0, 0);
    checkOutput("new_target", M_RV | M_PC | M_FL, 6'h00, 1, 32'h200, 1, 0, 4'h0);
    applyStimulus(1, 4'b0000, 0, 32'h0, 1);
    checkOutput("new_ack", M_RV | M_PC, 6'h00, 1, 32'h200, 1, 0, 4'h0);
    applyStimulus(1, 4'b0000, 0, 32'h0, 0);
    checkOutput("new_drop", M_RV | M_FL | M_CNT, 6'h00, 0, 32'h0, 0, 0, 4'h6);

    // Watchdog: 3 high, 1 low, 4 high
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4'b1000, 0, 32'h0, 0);
      checkOutput("wd_run1", M_ERR, 6'h00, 0, 32'h0, 0, 0, 4'h0);
    end
    applyStimulus(1, 4'b0000, 0, 32'h0, 0);
    checkOutput("wd_gap", M_ERR, 6'h00, 0, 32'h0, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 4'b1000, 0, 32'h0, 0);
      checkOutput("wd_run2", M_ERR, 6'h00, 0, 32'h0, 0, 0, 4'h0);
    end
    applyStimulus(1, 4'b0000, 0, 32'h0, 0);
    checkOutput("wd_set", M_ERR | M_CNT, 6'h00, 0, 32'h0, 0, 1, 4'hD);
    applyStimulus(1, 4'b0000, 0, 32'h0, 0);
    checkOutput("wd_sticky", M_ERR | M_CNT, 6'h00, 0, 32'h0, 0, 1, 4'hD);

    // Counter saturation, then async reset in the middle of a redirect
    for (int i = 0; i < 20; i++) applyStimulus(1, 4'b0001, 0, 32'h0, 0);
    applyStimulus(1, 4'b0000, 0, 32'h0, 0);
    checkOutput("cnt_sat", M_CNT, 6'h00, 0, 32'h0, 0, 1, 4'hF);
    applyStimulus(1, 4'b0000, 1, 32'h0000_0300, 0);
    applyStimulus(1, 4'b0000, 0, 32'h0, 0);
    checkOutput("rst_pre", M_RV | M_PC | M_FL, 6'h00, 1, 32'h300, 1, 1, 4'hF);
    applyStimulus(0, 4'b0010, 0, 32'h0, 0);
    checkOutput("rst_mid", M_ALL, 6'h00, 0, 32'h0, 0, 0, 4'h0);
    applyStimulus(1, 4'b0010, 0, 32'h0, 0);
    checkOutput("rst_after", M_ST | M_RV | M_CNT, 6'h07, 0, 32'h0, 0, 0, 4'h0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", sb.size());
    end
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
